// File: rtl/adc_pkg.sv
// Shared definitions for the ADC deserializer alignment block.
package adc_pkg;

    localparam int unsigned ADC_WIDTH = 10;
    localparam int unsigned ADC_DESER = 8;

    // Even slots carry this code during training; odd slots carry its inverse.
    localparam logic [ADC_WIDTH-1:0] ADC_TRAIN_PAT = 10'h2AA;

    typedef enum logic [2:0] {
        SETTLE,
        CHECK,
        SLIP,
        LOCKED,
        FAILED
    } adc_state_e;

endpackage

// File: rtl/adc_train_match.sv
// Combinational training-pattern comparator over one parallel ISERDES word.
module adc_train_match
    import adc_pkg::*;
#(
    parameter int unsigned      WIDTH     = ADC_WIDTH,
    parameter int unsigned      DESER     = ADC_DESER,
    parameter logic [WIDTH-1:0] TRAIN_PAT = WIDTH'(ADC_TRAIN_PAT)
) (
    input  logic [WIDTH*DESER-1:0] data_in,
    output logic                   match
);

    // Exact match: even slots equal TRAIN_PAT, odd slots equal its inverse.
    always_comb begin
        match = 1'b1;
        for (int unsigned k = 0; k < DESER; k++) begin
            if ((k % 2) == 0) begin
                if (data_in[WIDTH*k +: WIDTH] != TRAIN_PAT) match = 1'b0;
            end else begin
                if (data_in[WIDTH*k +: WIDTH] != ~TRAIN_PAT) match = 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_deser_align.sv
// Bitslip-based word alignment for the ADC ISERDES output, plus registered sample path.
module adc_deser_align
    import adc_pkg::*;
#(
    parameter int unsigned      WIDTH         = ADC_WIDTH,
    parameter int unsigned      DESER         = ADC_DESER,
    parameter logic [WIDTH-1:0] TRAIN_PAT     = WIDTH'(ADC_TRAIN_PAT),
    parameter int unsigned      SETTLE_CYCLES = 16,
    parameter int unsigned      CHECK_WORDS   = 64,
    parameter int unsigned      MAX_SLIPS     = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH*DESER-1:0] data_in,
    input  logic                   train_req,
    output logic                   bitslip,
    output logic                   locked,
    output logic                   fail,
    output logic [3:0]             slip_count,
    output logic [WIDTH*DESER-1:0] sample_data,
    output logic                   sample_valid
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned MATCH_W  = $clog2(CHECK_WORDS + 1);
    localparam int unsigned WORD_W   = WIDTH * DESER;

    adc_state_e           state_q, state_d;
    logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
    logic [3:0]           slip_cnt_q, slip_cnt_d;
    logic                 bitslip_q, bitslip_d;
    logic                 locked_q, locked_d;
    logic                 fail_q, fail_d;
    logic                 sample_valid_q, sample_valid_d;
    logic [WORD_W-1:0]    sample_data_q, sample_data_d;
    logic                 match;

    adc_train_match #(
        .WIDTH     (WIDTH),
        .DESER     (DESER),
        .TRAIN_PAT (TRAIN_PAT)
    ) u_match (
        .data_in (data_in),
        .match   (match)
    );

    // Next state, counters and registered-output values.
    always_comb begin
        state_d        = state_q;
        settle_cnt_d   = settle_cnt_q;
        match_cnt_d    = match_cnt_q;
        slip_cnt_d     = slip_cnt_q;
        sample_data_d  = data_in;

        unique case (state_q)
            SETTLE: begin
                if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    settle_cnt_d = '0;
                    match_cnt_d  = '0;
                    state_d      = CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end
            end
            CHECK: begin
                if (match) begin
                    match_cnt_d = match_cnt_q + MATCH_W'(1);
                    if (match_cnt_q == MATCH_W'(CHECK_WORDS - 1)) state_d = LOCKED;
                end else begin
                    match_cnt_d = '0;
                    if (slip_cnt_q == 4'(MAX_SLIPS)) begin
                        state_d = FAILED;
                    end else begin
                        state_d    = SLIP;
                        slip_cnt_d = (slip_cnt_q == 4'hF) ? slip_cnt_q : slip_cnt_q + 4'd1;
                    end
                end
            end
            SLIP: begin
                settle_cnt_d = '0;
                state_d      = SETTLE;
            end
            LOCKED, FAILED: begin
                state_d = state_q;
            end
            default: begin
                settle_cnt_d = '0;
                state_d      = SETTLE;
            end
        endcase

        // Retraining overrides every transition, including a pending lock.
        if (train_req) begin
            state_d      = SETTLE;
            settle_cnt_d = '0;
            match_cnt_d  = '0;
            slip_cnt_d   = '0;
        end

        bitslip_d      = (state_d == SLIP);
        locked_d       = (state_d == LOCKED);
        fail_d         = (state_d == FAILED);
        sample_valid_d = (state_q == LOCKED) && !train_req;
    end

    // FSM state and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SETTLE;
            settle_cnt_q <= '0;
            match_cnt_q  <= '0;
            slip_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            match_cnt_q  <= match_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
        end
    end

    // Registered outputs and sample path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bitslip_q      <= 1'b0;
            locked_q       <= 1'b0;
            fail_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
        end else begin
            bitslip_q      <= bitslip_d;
            locked_q       <= locked_d;
            fail_q         <= fail_d;
            sample_valid_q <= sample_valid_d;
            sample_data_q  <= sample_data_d;
        end
    end

    assign bitslip      = bitslip_q;
    assign locked       = locked_q;
    assign fail         = fail_q;
    assign slip_count   = slip_cnt_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_adc_deser_align.sv
// Directed self-checking bench for adc_deser_align.
module tb_adc_deser_align;

    localparam int M_ALIGN  = 0;
    localparam int M_ROT    = 1;
    localparam int M_ZERO   = 2;
    localparam int M_MANUAL = 3;

    logic        clk;
    logic        reset_n;
    logic [79:0] data_in;
    logic        train_req;
    logic        bitslip;
    logic        locked;
    logic        fail;
    logic [3:0]  slip_count;
    logic [79:0] sample_data;
    logic        sample_valid;

    int          n_cmp;
    int          n_err;
    int          cyc;
    int          n_slips;
    int          first_slip_cyc;
    int          last_slip_cyc;
    logic        bs_prev;
    int          mode;
    int          rot_base;
    int          lc;
    logic [79:0] aligned_w;
    logic [79:0] manual_w;

    adc_deser_align dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .train_req    (train_req),
        .bitslip      (bitslip),
        .locked       (locked),
        .fail         (fail),
        .slip_count   (slip_count),
        .sample_data  (sample_data),
        .sample_valid (sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [79:0] rotl(input logic [79:0] w, input int r);
        if (r == 0) return w;
        return (w << r) | (w >> (80 - r));
    endfunction

    // Drive data_in from the ISERDES model: misalignment shrinks by one bit per pulse.
    task automatic drive_model();
        int r;
        case (mode)
            M_ALIGN: data_in = aligned_w;
            M_ROT: begin
                r = (rot_base > n_slips) ? (rot_base - n_slips) : 0;
                data_in = rotl(aligned_w, r);
            end
            M_ZERO:  data_in = '0;
            default: data_in = manual_w;
        endcase
    endtask

    // Advance one clock, observe bitslip at the falling edge, then update stimulus.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bitslip) begin
            check_eq("slip_single_cycle", 80'(bs_prev), 80'd0);
            if (n_slips > 0) check_eq("slip_gap_ge18", 80'((cyc - last_slip_cyc) >= 18), 80'd1);
            if (n_slips == 0) first_slip_cyc = cyc;
            n_slips++;
            last_slip_cyc = cyc;
        end
        bs_prev = bitslip;
        drive_model();
    endtask

    task automatic wait_lock(input int budget, output int at);
        int n;
        n = 0;
        while (!locked && n < budget) begin
            tick();
            n++;
        end
        check_eq("lock_seen", 80'(locked), 80'd1);
        at = cyc;
    endtask

    task automatic restart(input int m);
        mode      = m;
        n_slips   = 0;
        train_req = 1'b1;
        tick();
        train_req = 1'b0;
        cyc       = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_bitslip"},  80'(bitslip),      80'd0);
        check_eq({tag, "_locked"},   80'(locked),       80'd0);
        check_eq({tag, "_fail"},     80'(fail),         80'd0);
        check_eq({tag, "_slipcnt"},  80'(slip_count),   80'd0);
        check_eq({tag, "_valid"},    80'(sample_valid), 80'd0);
        check_eq({tag, "_data"},     sample_data,       80'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; n_slips = 0;
        first_slip_cyc = 0; last_slip_cyc = 0; bs_prev = 1'b0;
        rot_base = 0; lc = 0; manual_w = '0;
        for (int k = 0; k < 8; k++) aligned_w[10*k +: 10] = ((k % 2) == 0) ? 10'h2AA : 10'h155;
        mode = M_ALIGN;
        data_in = aligned_w;
        train_req = 1'b0;
        reset_n = 1'b0;

        // Reset state, then aligned pattern from reset.
        tick(); tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        cyc = 0; n_slips = 0;
        repeat (79) tick();
        check_eq("s1_prelock", 80'(locked), 80'd0);
        wait_lock(10, lc);
        check_eq("s1_lock_window", 80'(lc >= 80 && lc <= 82), 80'd1);
        check_eq("s1_slipcnt", 80'(slip_count), 80'd0);
        check_eq("s1_no_pulse", 80'(n_slips), 80'd0);
        check_eq("s1_fail", 80'(fail), 80'd0);
        tick();
        check_eq("s1_valid", 80'(sample_valid), 80'd1);
        manual_w = 80'hDEAD_BEEF_0123_4567_89AB;
        mode = M_MANUAL;
        data_in = manual_w;
        tick();
        check_eq("s1_sample_data", sample_data, manual_w);
        check_eq("s1_stay_locked", 80'(locked), 80'd1);

        // train_req while locked, then relock.
        restart(M_ALIGN);
        check_eq("s2_locked_clr", 80'(locked), 80'd0);
        check_eq("s2_valid_clr", 80'(sample_valid), 80'd0);
        check_eq("s2_slipcnt_clr", 80'(slip_count), 80'd0);
        repeat (79) tick();
        check_eq("s2_prelock", 80'(locked), 80'd0);
        wait_lock(10, lc);
        check_eq("s2_lock_window", 80'(lc >= 80 && lc <= 82), 80'd1);

        // Misaligned by three bit positions.
        rot_base = 3;
        restart(M_ROT);
        wait_lock(300, lc);
        check_eq("s3_n_pulses", 80'(n_slips), 80'd3);
        check_eq("s3_slipcnt", 80'(slip_count), 80'd3);
        check_eq("s3_first_pulse", 80'(first_slip_cyc), 80'd17);
        check_eq("s3_last_pulse", 80'(last_slip_cyc), 80'd53);
        check_eq("s3_lock_cycle", 80'(lc), 80'(last_slip_cyc + 81));

        // Never matching: exhaust slips and fail.
        restart(M_ZERO);
        begin
            int n;
            n = 0;
            while (!fail && n < 400) begin
                tick();
                n++;
            end
        end
        check_eq("s4_fail", 80'(fail), 80'd1);
        check_eq("s4_fail_cycle", 80'(cyc), 80'(last_slip_cyc + 18));
        check_eq("s4_locked", 80'(locked), 80'd0);
        check_eq("s4_valid", 80'(sample_valid), 80'd0);
        check_eq("s4_slipcnt", 80'(slip_count), 80'd15);
        check_eq("s4_n_pulses", 80'(n_slips), 80'd15);
        repeat (60) tick();
        check_eq("s4_no_more_pulses", 80'(n_slips), 80'd15);
        check_eq("s4_fail_sticky", 80'(fail), 80'd1);
        check_eq("s4_locked_sticky", 80'(locked), 80'd0);

        // Glitch after 40 matches restarts the count.
        restart(M_ALIGN);
        repeat (56) tick();
        mode = M_MANUAL;
        manual_w = aligned_w ^ 80'd1;
        data_in = manual_w;
        tick();
        check_eq("s5_glitch_slip", 80'(bitslip), 80'd1);
        check_eq("s5_slipcnt", 80'(slip_count), 80'd1);
        mode = M_ALIGN;
        data_in = aligned_w;
        wait_lock(200, lc);
        check_eq("s5_lock_cycle", 80'(lc), 80'd138);
        check_eq("s5_n_pulses", 80'(n_slips), 80'd1);

        // Async reset mid-SETTLE with a nonzero slip count.
        rot_base = 3;
        restart(M_ROT);
        repeat (22) tick();
        check_eq("s6_pre_slipcnt", 80'(slip_count), 80'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("s6_settle_rst");
        tick(); tick();
        reset_n = 1'b1;
        cyc = 0; n_slips = 0; mode = M_ZERO;
        repeat (35) tick();
        check_eq("s6_pulse2", 80'(bitslip), 80'd1);
        check_eq("s6_pulse2_cnt", 80'(slip_count), 80'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("s6_slip_rst");
        tick();
        reset_n = 1'b1;
        cyc = 0; n_slips = 0; mode = M_ALIGN;
        repeat (79) tick();
        check_eq("s6_prelock", 80'(locked), 80'd0);
        wait_lock(10, lc);
        check_eq("s6_lock_window", 80'(lc >= 80 && lc <= 82), 80'd1);
        check_eq("s6_n_pulses", 80'(n_slips), 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_deser_align.md
Name: adc_deser_align

Overview:
- Sits directly downstream of the ADC ISERDES wrapper in the clk_156M domain.
- Consumes the 80-bit parallel word: 8 time-ordered 10-bit ADC samples per cycle.
- During ADC training mode it drives the ISERDES BITSLIP input until the known training pattern is seen.
- Once aligned, it forwards registered samples with a valid flag to capture/debug logic.

Parameters:
- WIDTH, 10, ADC sample width in bits.
- DESER, 8, samples per parallel word.
- TRAIN_PAT, 10'h2AA, expected code at even sample slots; odd slots expect ~TRAIN_PAT.
- SETTLE_CYCLES, 16, cycles to wait after reset or bitslip before comparing.
- CHECK_WORDS, 64, consecutive matching words required to declare lock.
- MAX_SLIPS, 15, bitslip attempts before declaring failure.

Ports:
- clk, input, 1, clk_156M divided ISERDES clock.
- reset_n, input, 1, reset.
- data_in, input, WIDTH*DESER, ISERDES parallel word; sample k = data_in[WIDTH*k +: WIDTH], k=0 oldest.
- train_req, input, 1, single-cycle pulse; restart alignment from any state.
- bitslip, output, 1, one-cycle pulse to the ISERDES BITSLIP input.
- locked, output, 1, alignment achieved.
- fail, output, 1, MAX_SLIPS exhausted without lock.
- slip_count, output, 4, bitslips issued since the last (re)start.
- sample_data, output, WIDTH*DESER, registered copy of data_in.
- sample_valid, output, 1, sample_data is aligned ADC data.

Interface (already decided): one clock; reset is asynchronous and active-low (clk, reset_n).

Behaviour:
- Reset values: all outputs 0; FSM = SETTLE; counters = 0.
- Match condition, combinational on data_in: every even slot == TRAIN_PAT and every odd slot == ~TRAIN_PAT (10 bits). Exact equality only.
- FSM states:
  - SETTLE: settle counter runs 0..SETTLE_CYCLES-1. On the terminal count, clear the match counter and go to CHECK.
  - CHECK, on a matching word: match counter increments. When it reaches CHECK_WORDS, go to LOCKED.
  - CHECK, on a non-matching word: if slip_count == MAX_SLIPS, go to FAILED. Otherwise go to SLIP.
  - SLIP: bitslip = 1 for exactly this one cycle; slip_count increments (saturates at 15); go to SETTLE.
  - LOCKED: locked = 1, sample_valid = 1. No pattern checking; stays until train_req or reset.
  - FAILED: fail = 1, locked = 0, sample_valid = 0, bitslip = 0. Stays until train_req or reset.
- Lock and fail timing: locked asserts the cycle after the CHECK_WORDS-th match is sampled. fail asserts the cycle after the failing mismatch.
- Mismatch resets the match count; lock requires CHECK_WORDS strictly consecutive matches.
- Bitslip spacing: at least SETTLE_CYCLES+2 cycles between pulses. Bitslip is never asserted outside SLIP.
- train_req:
  - In any state: next cycle locked = 0, fail = 0, sample_valid = 0, slip_count = 0, state = SETTLE.
  - Coinciding with the SLIP cycle: the bitslip pulse in that cycle still completes.
  - Coinciding with the lock transition: train_req wins.
- Data path: sample_data <= data_in every cycle regardless of state, 1-cycle latency. sample_valid is registered in step, so it marks data sampled while LOCKED.
- Asynchronous reset mid-operation: immediately returns all outputs to reset values.

Decomposition:
- Shared package adc_pkg holds:
  - localparams ADC_WIDTH = 10 and ADC_DESER = 8;
  - the FSM state enum {SETTLE, CHECK, SLIP, LOCKED, FAILED};
  - the default training pattern.
- One sub-module, adc_train_match: combinational pattern comparator. Parameterised by WIDTH, DESER and TRAIN_PAT; output match.

Test Plan:
- Aligned pattern from reset: data_in = {2AA,155} alternating, matching from cycle 0. Expect locked = 1 at cycle 16+64+1 (±1), slip_count = 0, bitslip never pulses.
- Misaligned by 3 slips: bench model rotates the pattern one bit per bitslip pulse and matches after the 3rd. Expect exactly 3 single-cycle pulses ≥18 cycles apart, then locked, with slip_count = 3.
- Never matching (constant 0): expect 15 bitslip pulses, then fail = 1 and locked = 0 permanently. slip_count = 15, no further pulses.
- Glitch during CHECK: one corrupted word after 40 matches. Expect a bitslip pulse and a restarted count; lock only after a further 64 consecutive matches.
- train_req while LOCKED: next cycle locked = 0, sample_valid = 0, slip_count = 0; re-lock follows the scenario 1 timing.
- Async reset asserted mid-SETTLE and during a bitslip pulse: all outputs 0 immediately; normal sequence restarts after release.
